// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencing controller.
package counter_seq_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;
  localparam int unsigned MODE_W        = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  typedef enum logic [MODE_W-1:0] {
    MODE_OS_DOWN  = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_OS_UP    = 2'd3
  } mode_t;

  // Initial count direction for a mode: 1 = down, 0 = up.
  function automatic logic mode_counts_down(input mode_t m);
    return (m == MODE_OS_DOWN) || (m == MODE_PERIODIC);
  endfunction

endpackage

// File: rtl/counter_seq_term.sv
// Terminal-value detector: selects the bound for the current direction and mode
// and compares it with the fed-back counter value.
module counter_seq_term
  import counter_seq_pkg::*;
#(
  parameter int unsigned N = CNT_W_DEFAULT
) (
  input  mode_t          i_mode,
  input  logic           i_dir,
  input  logic [N-1:0]   i_reload,
  input  logic [N-1:0]   i_limit,
  input  logic [N-1:0]   i_cnt,
  output logic           o_at_term_c
);

  logic [N-1:0] w_term;

  // Up-counting stops at the limit; down-counting stops at the reload value
  // in ping-pong and at zero otherwise.
  always_comb begin
    w_term = '0;
    if (!i_dir) begin
      w_term = i_limit;
    end else if (i_mode == MODE_PINGPONG) begin
      w_term = i_reload;
    end
  end

  assign o_at_term_c = (i_cnt == w_term);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller turning a loadable up/down counter into a timer with
// one-shot down, periodic down, ping-pong and one-shot up modes.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int unsigned N = CNT_W_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [MODE_W-1:0] i_mode,
  input  logic [N-1:0]      i_reload_val,
  input  logic [N-1:0]      i_limit,
  input  logic [N-1:0]      i_cnt,
  output logic              o_e_c,
  output logic              o_d_c,
  output logic              o_load_c,
  output logic [N-1:0]      o_load_val,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_tick,
  output logic              o_err
);

  state_t       r_state;
  mode_t        r_mode;
  logic [N-1:0] r_reload;
  logic [N-1:0] r_limit;
  logic         r_dir;
  logic         r_busy;
  logic         r_done;
  logic         r_tick;
  logic         r_err;

  logic         w_at_term;
  logic         w_reject;
  logic         w_oneshot;
  mode_t        w_mode_in;

  assign w_mode_in = mode_t'(i_mode);
  assign w_reject  = (w_mode_in == MODE_PINGPONG) && (i_limit <= i_reload_val);
  assign w_oneshot = (r_mode == MODE_OS_DOWN) || (r_mode == MODE_OS_UP);

  counter_seq_term #(.N(N)) u_term (
    .i_mode      (r_mode),
    .i_dir       (r_dir),
    .i_reload    (r_reload),
    .i_limit     (r_limit),
    .i_cnt       (i_cnt),
    .o_at_term_c (w_at_term)
  );

  // Sequencer state, latched configuration and registered status pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_mode   <= MODE_OS_DOWN;
      r_reload <= '0;
      r_limit  <= '0;
      r_dir    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_tick   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_tick <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!i_stop && i_start) begin
            if (w_reject) begin
              r_err <= 1'b1;
            end else begin
              r_mode   <= w_mode_in;
              r_reload <= i_reload_val;
              r_limit  <= i_limit;
              r_dir    <= mode_counts_down(w_mode_in);
              r_state  <= ST_LOADING;
              r_busy   <= 1'b1;
            end
          end
        end
        ST_LOADING: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (i_stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_at_term) begin
            if (w_oneshot) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_tick <= 1'b1;
              if (r_mode == MODE_PINGPONG) begin
                r_dir <= ~r_dir;
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Counter control strobes; LOAD and E are mutually exclusive by construction.
  always_comb begin
    o_e_c    = 1'b0;
    o_load_c = 1'b0;
    o_d_c    = r_dir;
    case (r_state)
      ST_LOADING: o_load_c = 1'b1;
      ST_RUN: begin
        if (!i_stop) begin
          if (w_oneshot) begin
            o_e_c = !w_at_term;
          end else if (r_mode == MODE_PERIODIC) begin
            o_load_c = w_at_term;
            o_e_c    = !w_at_term;
          end else begin
            o_e_c = 1'b1;
            if (w_at_term) begin
              o_d_c = ~r_dir;
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign o_load_val = r_reload;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_tick     = r_tick;
  assign o_err      = r_err;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: a stand-in counter closes the loop and every
// cycle is compared with a closed-form per-mode expectation.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] reload_val = 8'd0;
  logic [7:0] limit = 8'd0;
  logic [7:0] cnt = 8'd0;
  logic       e, d, load, busy, done, tick, err;
  logic [7:0] load_val;
  int         checks = 0;
  int         failures = 0;

  typedef struct packed {
    logic       e;
    logic       d;
    logic       load;
    logic       busy;
    logic       done;
    logic       tick;
    logic [7:0] cnt;
  } exp_t;

  always #5 clk = ~clk;

  counter_seq_ctrl #(.N(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_stop       (stop),
    .i_mode       (mode),
    .i_reload_val (reload_val),
    .i_limit      (limit),
    .i_cnt        (cnt),
    .o_e_c        (e),
    .o_d_c        (d),
    .o_load_c     (load),
    .o_load_val   (load_val),
    .o_busy       (busy),
    .o_done       (done),
    .o_tick       (tick),
    .o_err        (err)
  );

  // Controlled counter: no reset, load has priority over enable.
  always @(posedge clk) begin
    if (load) cnt <= load_val;
    else if (e) cnt <= d ? cnt - 8'd1 : cnt + 8'd1;
  end

  // Expected outputs t cycles after START acceptance (t=0 is the load cycle),
  // written as arithmetic sequences per mode.
  function automatic exp_t model(input int m, input int r, input int l, input int t);
    exp_t x;
    int j, p, ph, nn;
    x = '0;
    x.busy = 1'b1;
    x.d = (m < 2);
    if (t == 0) begin
      x.load = 1'b1;
      return x;
    end
    j = t - 1;
    case (m)
      0: begin
        if (j <= r) begin
          x.cnt = 8'(r - j);
          x.e = (j != r);
        end else begin
          x.busy = 1'b0; x.done = 1'b1; x.cnt = 8'd0;
        end
      end
      1: begin
        x.cnt  = 8'(r - (j % (r + 1)));
        x.load = (x.cnt == 8'd0);
        x.e    = !x.load;
        x.tick = (j >= 1) && (((j - 1) % (r + 1)) == r);
      end
      2: begin
        p  = l - r;
        ph = j % (2 * p);
        x.cnt  = 8'(r + ((ph <= p) ? ph : (2 * p - ph)));
        x.e    = 1'b1;
        x.d    = (ph >= p);
        x.tick = ((j >= 1) && (((j - 1) % (2 * p)) == p)) ||
                 ((j >= 2) && (((j - 1) % (2 * p)) == 0));
      end
      default: begin
        nn = (l - r) & 255;
        if (j <= nn) begin
          x.cnt = 8'((r + j) & 255);
          x.e = (j != nn);
        end else begin
          x.busy = 1'b0; x.done = 1'b1; x.cnt = 8'(l);
        end
      end
    endcase
    return x;
  endfunction

  task automatic launch(input int m, input int r, input int l);
    @(negedge clk);
    mode = 2'(m); reload_val = 8'(r); limit = 8'(l); start = 1'b1; stop = 1'b0;
  endtask

  task automatic scramble();
    start = 1'b0;
    mode = 2'($urandom); reload_val = 8'($urandom); limit = 8'($urandom);
  endtask

  task automatic halt();
    @(negedge clk); start = 1'b0; stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic test_reset();
    exp_t x;
    repeat (2) @(negedge clk);
    checks++;
    if ({e, d, load, load_val, busy, done, tick, err} !== 15'd0) begin
      failures++;
      $display("FAIL reset_values got=%b exp=0", {e, d, load, load_val, busy, done, tick, err});
    end
    rst = 1'b0;
    launch(1, 20, 0);
    for (int t = 0; t <= 5; t++) begin
      @(negedge clk);
      scramble();
    end
    x = model(1, 20, 0, 5);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({e, d, load, load_val, busy, done, tick, err} !== 15'd0) begin
      failures++;
      $display("FAIL reset_midrun got=%b exp=0", {e, d, load, load_val, busy, done, tick, err});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cnt !== x.cnt) begin
      failures++;
      $display("FAIL reset_freeze busy=%b cnt=%0d exp busy=0 cnt=%0d", busy, cnt, x.cnt);
    end
  endtask

  task automatic test_oneshot_down();
    int r;
    exp_t x;
    for (int k = 0; k < 5; k++) begin
      r = (k == 0) ? 4 : (k == 1) ? 3 : int'($urandom_range(0, 60));
      launch(0, r, 0);
      for (int t = 0; t <= r + 2; t++) begin
        @(negedge clk);
        x = model(0, r, 0, t);
        checks++;
        if ({e, d, load, busy, done, tick, err} !== {x.e, x.d, x.load, x.busy, x.done, x.tick, 1'b0}) begin
          failures++;
          $display("FAIL oneshot_down_ctrl r=%0d t=%0d got=%b exp=%b", r, t,
                   {e, d, load, busy, done, tick, err}, {x.e, x.d, x.load, x.busy, x.done, x.tick, 1'b0});
        end
        checks++;
        if ((t > 0 && cnt !== x.cnt) || (t == 0 && load_val !== 8'(r))) begin
          failures++;
          $display("FAIL oneshot_down_cnt r=%0d t=%0d cnt=%0d load_val=%0d exp=%0d", r, t, cnt, load_val, x.cnt);
        end
        scramble();
      end
    end
  endtask

  task automatic test_periodic();
    int r, ncyc;
    exp_t x;
    for (int k = 0; k < 4; k++) begin
      r = (k == 0) ? 2 : (k == 1) ? 0 : int'($urandom_range(1, 15));
      ncyc = (k == 0) ? 12 : 3 * (r + 1) + 2;
      launch(1, r, 0);
      for (int t = 0; t <= ncyc; t++) begin
        @(negedge clk);
        x = model(1, r, 0, t);
        checks++;
        if ({e, d, load, busy, done, tick, err} !== {x.e, x.d, x.load, x.busy, x.done, x.tick, 1'b0} ||
            (t > 0 && cnt !== x.cnt)) begin
          failures++;
          $display("FAIL periodic r=%0d t=%0d got=%b cnt=%0d exp=%b cnt=%0d", r, t,
                   {e, d, load, busy, done, tick, err}, cnt, {x.e, x.d, x.load, x.busy, x.done, x.tick, 1'b0}, x.cnt);
        end
        scramble();
      end
      halt();
    end
  endtask

  task automatic test_pingpong();
    int r, l;
    exp_t x;
    for (int k = 0; k < 4; k++) begin
      r = (k == 0) ? 5 : int'($urandom_range(0, 200));
      l = (k == 0) ? 8 : ((k == 1) ? r + 1 : r + int'($urandom_range(1, 20)));
      if (l > 255) l = 255;
      if (l <= r) r = l - 1;
      launch(2, r, l);
      for (int t = 0; t <= 4 * (l - r) + 3; t++) begin
        @(negedge clk);
        x = model(2, r, l, t);
        checks++;
        if ({e, d, load, busy, done, tick, err} !== {x.e, x.d, x.load, x.busy, x.done, x.tick, 1'b0} ||
            (t > 0 && cnt !== x.cnt)) begin
          failures++;
          $display("FAIL pingpong r=%0d l=%0d t=%0d got=%b cnt=%0d exp=%b cnt=%0d", r, l, t,
                   {e, d, load, busy, done, tick, err}, cnt, {x.e, x.d, x.load, x.busy, x.done, x.tick, 1'b0}, x.cnt);
        end
        scramble();
      end
      halt();
    end
  endtask

  task automatic test_err();
    int r, l;
    for (int k = 0; k < 3; k++) begin
      r = (k == 0) ? 5 : int'($urandom_range(0, 255));
      l = (k == 0) ? 5 : int'($urandom_range(0, r));
      launch(2, r, l);
      @(negedge clk);
      checks++;
      if ({err, busy, load, e} !== 4'b1000) begin
        failures++;
        $display("FAIL err_pulse r=%0d l=%0d got err,busy,load,e=%b exp=1000", r, l, {err, busy, load, e});
      end
      start = 1'b0;
      @(negedge clk);
      checks++;
      if ({err, busy, load, e} !== 4'b0000) begin
        failures++;
        $display("FAIL err_clear r=%0d l=%0d got err,busy,load,e=%b exp=0000", r, l, {err, busy, load, e});
      end
    end
  endtask

  task automatic test_oneshot_up();
    int r, l, nn;
    exp_t x;
    // Directed wrap case with START held: the second run follows the DONE cycle.
    launch(3, 254, 1);
    for (int pass = 0; pass < 2; pass++) begin
      for (int t = 0; t <= 5; t++) begin
        @(negedge clk);
        x = model(3, 254, 1, t);
        checks++;
        if ({e, d, load, busy, done, tick, err} !== {x.e, x.d, x.load, x.busy, x.done, x.tick, 1'b0} ||
            (t > 0 && cnt !== x.cnt) || load_val !== 8'hFE) begin
          failures++;
          $display("FAIL oneshot_up_held pass=%0d t=%0d got=%b cnt=%0d exp=%b cnt=%0d", pass, t,
                   {e, d, load, busy, done, tick, err}, cnt, {x.e, x.d, x.load, x.busy, x.done, x.tick, 1'b0}, x.cnt);
        end
        if (pass == 1 && t == 0) start = 1'b0;
      end
    end
    for (int k = 0; k < 3; k++) begin
      r = int'($urandom_range(0, 255));
      l = int'($urandom_range(0, 255));
      nn = (l - r) & 255;
      launch(3, r, l);
      for (int t = 0; t <= nn + 2; t++) begin
        @(negedge clk);
        x = model(3, r, l, t);
        checks++;
        if ({e, d, load, busy, done, tick, err} !== {x.e, x.d, x.load, x.busy, x.done, x.tick, 1'b0} ||
            (t > 0 && cnt !== x.cnt)) begin
          failures++;
          $display("FAIL oneshot_up r=%0d l=%0d t=%0d got=%b cnt=%0d exp=%b cnt=%0d", r, l, t,
                   {e, d, load, busy, done, tick, err}, cnt, {x.e, x.d, x.load, x.busy, x.done, x.tick, 1'b0}, x.cnt);
        end
        scramble();
      end
    end
  endtask

  task automatic test_stop();
    exp_t x;
    @(negedge clk);
    mode = 2'd0; reload_val = 8'd5; limit = 8'd9; start = 1'b1; stop = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      checks++;
      if ({busy, load, e, err, done} !== 5'd0) begin
        failures++;
        $display("FAIL stop_start_idle t=%0d got busy,load,e,err,done=%b exp=00000", t, {busy, load, e, err, done});
      end
    end
    start = 1'b0; stop = 1'b0;
    launch(1, 8'h50, 0);
    for (int t = 0; t <= 8'h11; t++) begin
      @(negedge clk);
      x = model(1, 8'h50, 0, t);
      checks++;
      if ({e, d, load, busy, tick} !== {x.e, x.d, x.load, x.busy, x.tick} || (t > 0 && cnt !== x.cnt)) begin
        failures++;
        $display("FAIL stop_prerun t=%0d got=%b cnt=%0d exp=%b cnt=%0d", t, {e, d, load, busy, tick}, cnt,
                 {x.e, x.d, x.load, x.busy, x.tick}, x.cnt);
      end
      scramble();
    end
    stop = 1'b1;
    #1;
    checks++;
    if ({e, load} !== 2'b00) begin
      failures++;
      $display("FAIL stop_comb got e,load=%b exp=00", {e, load});
    end
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      stop = 1'b0;
      checks++;
      if ({busy, tick, done, e, load} !== 5'd0 || cnt !== 8'h40) begin
        failures++;
        $display("FAIL stop_freeze t=%0d got busy,tick,done,e,load=%b cnt=%0h exp=00000 cnt=40", t,
                 {busy, tick, done, e, load}, cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot_down();
    test_periodic();
    test_pingpong();
    test_err();
    test_oneshot_up();
    test_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
